// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module : multdiv_pkg
// Brief  : Shared types and constants for the RV32M multiply/divide unit.
// Rev    : 1.0
// ============================================================================
package multdiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_md_e;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    CALCULA   = 2'd1,
    AJUSTE    = 2'd2,
    CONCLUIDO = 2'd3
  } estado_md_e;

  localparam int          ITER       = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  function automatic logic eh_divisao(input op_md_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage
`default_nettype wire

// File: rtl/nucleo_iterativo.sv
`default_nettype none
// ============================================================================
// Module : nucleo_iterativo
// Brief  : One combinational step of shift-add multiply or restoring divide.
// Rev    : 1.0
// ============================================================================
module nucleo_iterativo #(
  parameter int LARGURA = 32
) (
  input  logic                   eh_div,
  input  logic [2*LARGURA-1:0]   acc_in,
  input  logic [LARGURA-1:0]     rem_in,
  input  logic [LARGURA-1:0]     oper_in,
  output logic [2*LARGURA-1:0]   acc_out,
  output logic [LARGURA-1:0]     rem_out
);

  logic [LARGURA:0] soma;
  logic [LARGURA:0] desloc;
  logic             cabe;

  always_comb begin
    soma    = {1'b0, acc_in[2*LARGURA-1:LARGURA]} + (acc_in[0] ? {1'b0, oper_in} : '0);
    desloc  = {rem_in, acc_in[LARGURA-1]};
    cabe    = (desloc >= {1'b0, oper_in});
    acc_out = acc_in;
    rem_out = rem_in;
    if (eh_div) begin
      // Remainder stays below the divisor, so after a successful subtract it fits LARGURA bits.
      rem_out = cabe ? LARGURA'(desloc - {1'b0, oper_in}) : desloc[LARGURA-1:0];
      acc_out = {acc_in[2*LARGURA-1:LARGURA], acc_in[LARGURA-2:0], cabe};
    end else begin
      acc_out = {soma, acc_in[LARGURA-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/unidade_mult_div.sv
`default_nettype none
// ============================================================================
// Module : unidade_mult_div
// Brief  : Iterative RV32M multiply/divide with valid/ready on both sides.
//          `MULTDIV_MUL_RAPIDO_EN selects a single-cycle multiply path.
// Rev    : 1.0
// ============================================================================
module unidade_mult_div
  import multdiv_pkg::*;
#(
  parameter int LARGURA  = 32,
  parameter int LARG_END = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                valido_in,
  output logic                pronto_in,
  input  logic [2:0]          funct3,
  input  logic [LARGURA-1:0]  operando_a,
  input  logic [LARGURA-1:0]  operando_b,
  input  logic [LARG_END-1:0] regd_in,
  output logic                valido_out,
  input  logic                pronto_out,
  output logic [LARGURA-1:0]  resultado,
  output logic [LARG_END-1:0] regd_out
);

  estado_md_e            estado_q, estado_d;
  logic [4:0]            cont_q, cont_d;
  logic                  prep_q, prep_d;
  logic [2*LARGURA-1:0]  acc_q, acc_d;
  logic [LARGURA-1:0]    rem_q, rem_d;
  logic [LARGURA-1:0]    oper_q, oper_d;
  op_md_e                op_q, op_d;
  logic                  sinal_a_q, sinal_a_d;
  logic                  sinal_b_q, sinal_b_d;
  logic [LARG_END-1:0]   regd_q, regd_d;
  logic [LARGURA-1:0]    resultado_q, resultado_d;

  op_md_e                op_in;
  logic                  sa_in, sb_in, div_zero, overflow;
  logic [2*LARGURA-1:0]  acc_passo, prod_f;
  logic [LARGURA-1:0]    rem_passo, quot_f, rem_f, res_ajuste;
  logic                  div_q;

  assign op_in    = op_md_e'(funct3);
  assign sa_in    = operando_a[LARGURA-1] & (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign sb_in    = operando_b[LARGURA-1] & (op_in inside {OP_MULH, OP_DIV, OP_REM});
  assign div_zero = eh_divisao(op_in) && (operando_b == '0);
  assign overflow = (op_in inside {OP_DIV, OP_REM}) && (operando_a == INT_MIN) && (operando_b == '1);
  assign div_q    = eh_divisao(op_q);

`ifdef MULTDIV_MUL_RAPIDO_EN
  logic [2*LARGURA-1:0] ext_a, ext_b, prod_rapido;
  assign ext_a       = {{LARGURA{sa_in}}, operando_a};
  assign ext_b       = {{LARGURA{sb_in}}, operando_b};
  assign prod_rapido = ext_a * ext_b;
`endif

  nucleo_iterativo #(.LARGURA(LARGURA)) u_nucleo (
    .eh_div  (div_q),
    .acc_in  (acc_q),
    .rem_in  (rem_q),
    .oper_in (oper_q),
    .acc_out (acc_passo),
    .rem_out (rem_passo)
  );

  always_comb begin
    prod_f = (sinal_a_q ^ sinal_b_q) ? -acc_q : acc_q;
    quot_f = (sinal_a_q ^ sinal_b_q) ? -acc_q[LARGURA-1:0] : acc_q[LARGURA-1:0];
    rem_f  = sinal_a_q ? -rem_q : rem_q;
    case (op_q)
      OP_MUL:                       res_ajuste = prod_f[LARGURA-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_ajuste = prod_f[2*LARGURA-1:LARGURA];
      OP_DIV, OP_DIVU:              res_ajuste = quot_f;
      default:                      res_ajuste = rem_f;
    endcase
  end

  always_comb begin
    estado_d    = estado_q;
    cont_d      = cont_q;
    prep_d      = prep_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    oper_d      = oper_q;
    op_d        = op_q;
    sinal_a_d   = sinal_a_q;
    sinal_b_d   = sinal_b_q;
    regd_d      = regd_q;
    resultado_d = resultado_q;
    case (estado_q)
      OCIOSO: begin
        if (valido_in) begin
          op_d      = op_in;
          regd_d    = regd_in;
          sinal_a_d = sa_in;
          sinal_b_d = sb_in;
          acc_d     = {{LARGURA{1'b0}}, operando_a};
          oper_d    = operando_b;
          rem_d     = '0;
          cont_d    = 5'(ITER - 1);
          prep_d    = 1'b1;
          if (div_zero) begin
            resultado_d = (op_in inside {OP_DIV, OP_DIVU}) ? DIV_ZERO_Q : operando_a;
            estado_d    = CONCLUIDO;
          end else if (overflow) begin
            resultado_d = (op_in == OP_DIV) ? INT_MIN : '0;
            estado_d    = CONCLUIDO;
          end
`ifdef MULTDIV_MUL_RAPIDO_EN
          else if (!eh_divisao(op_in)) begin
            resultado_d = (op_in == OP_MUL) ? prod_rapido[LARGURA-1:0]
                                            : prod_rapido[2*LARGURA-1:LARGURA];
            estado_d    = CONCLUIDO;
          end
`endif
          else begin
            estado_d = CALCULA;
          end
        end
      end
      CALCULA: begin
        // Operands are latched raw; the first cycle folds them into magnitudes.
        if (prep_q) begin
          prep_d = 1'b0;
          acc_d  = {{LARGURA{1'b0}}, (sinal_a_q ? -acc_q[LARGURA-1:0] : acc_q[LARGURA-1:0])};
          oper_d = sinal_b_q ? -oper_q : oper_q;
        end else begin
          acc_d  = acc_passo;
          rem_d  = rem_passo;
          cont_d = cont_q - 5'd1;
          if (cont_q == 5'd0) estado_d = AJUSTE;
        end
      end
      AJUSTE: begin
        resultado_d = res_ajuste;
        estado_d    = CONCLUIDO;
      end
      CONCLUIDO: begin
        if (pronto_out) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q    <= OCIOSO;
      cont_q      <= '0;
      prep_q      <= 1'b0;
      acc_q       <= '0;
      rem_q       <= '0;
      oper_q      <= '0;
      op_q        <= OP_MUL;
      sinal_a_q   <= 1'b0;
      sinal_b_q   <= 1'b0;
      regd_q      <= '0;
      resultado_q <= '0;
    end else begin
      estado_q    <= estado_d;
      cont_q      <= cont_d;
      prep_q      <= prep_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      oper_q      <= oper_d;
      op_q        <= op_d;
      sinal_a_q   <= sinal_a_d;
      sinal_b_q   <= sinal_b_d;
      regd_q      <= regd_d;
      resultado_q <= resultado_d;
    end
  end

  assign pronto_in  = (estado_q == OCIOSO);
  assign valido_out = (estado_q == CONCLUIDO);
  assign resultado  = resultado_q;
  assign regd_out   = regd_q;

endmodule
`default_nettype wire
